// File: rtl/l1_ahb_mtx_in_stg.sv
// -----------------------------------------------------------------------------
// l1_ahb_mtx_in_stg
// Input stage for one master port of the L1 AHB bus matrix. Decodes each
// address phase to output 0 or output 1, captures and holds the address phase
// when the target output has not granted this port (stalling the master via
// HREADYOUTS), and tracks which output owns the data phase so that output's
// ready/response is returned to the master.
//
// Optional feature macro: L1_AHB_MTX_IN_STG_DEFSLV_EN
//   defined   : decode miss answers with a two-cycle AHB ERROR (ERR1, ERR2)
//   undefined : decode miss completes OKAY with zero wait states
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSELS..HMASTLOCKS     master address phase
//   HREADYS               master-side HREADY (HREADYOUTS looped back)
//   HREADYOUTS, HRESPS    ready / response to the master
//   HADDRI..HMASTLOCKI    address phase to the output stages (held or live)
//   sel_m0, sel_m1        request to output 0 / 1
//   active_m0, active_m1  output 0 / 1 currently grants this port
//   hready_m0, hready_m1  output 0 / 1 HREADYM
//   readyout_m0/_m1       data-phase HREADYOUT from output 0 / 1
//   resp_m0/_m1           data-phase HRESP from output 0 / 1
// -----------------------------------------------------------------------------
module l1_ahb_mtx_in_stg #(
   parameter int                ADDR_W  = 32,
   parameter logic [ADDR_W-1:0] M0_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] M0_MASK = 32'hE000_0000,
   parameter logic [ADDR_W-1:0] M1_BASE = 32'h2000_0000,
   parameter logic [ADDR_W-1:0] M1_MASK = 32'hE000_0000
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSELS,
   input  logic [ADDR_W-1:0] HADDRS,
   input  logic [1:0]        HTRANSS,
   input  logic              HWRITES,
   input  logic [2:0]        HSIZES,
   input  logic [2:0]        HBURSTS,
   input  logic [3:0]        HPROTS,
   input  logic              HMASTLOCKS,
   input  logic              HREADYS,
   output logic              HREADYOUTS,
   output logic              HRESPS,
   output logic [ADDR_W-1:0] HADDRI,
   output logic [1:0]        HTRANSI,
   output logic              HWRITEI,
   output logic [2:0]        HSIZEI,
   output logic [2:0]        HBURSTI,
   output logic [3:0]        HPROTI,
   output logic              HMASTLOCKI,
   output logic              sel_m0,
   output logic              sel_m1,
   input  logic              active_m0,
   input  logic              active_m1,
   input  logic              hready_m0,
   input  logic              hready_m1,
   input  logic              readyout_m0,
   input  logic              readyout_m1,
   input  logic              resp_m0,
   input  logic              resp_m1
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PEND,
      ST_DATA,
      ST_DATA_PEND
`ifdef L1_AHB_MTX_IN_STG_DEFSLV_EN
      ,
      ST_ERR1,
      ST_ERR2
`endif
   } state_t;

   typedef enum logic [1:0] {
      DS_NONE,
      DS_M0,
      DS_M1,
      DS_MISS
   } dsel_t;

   state_t            state_reg;
   state_t            state_next;
   logic              pend_reg;
   logic              pend_next;
   dsel_t             dsel_reg;
   dsel_t             dsel_next;

   // Held copy of the address phase
   logic [ADDR_W-1:0] held_addr_reg;
   logic [1:0]        held_trans_reg;
   logic              held_write_reg;
   logic [2:0]        held_size_reg;
   logic [2:0]        held_burst_reg;
   logic [3:0]        held_prot_reg;
   logic              held_lock_reg;

   logic [1:0]        hit;
   logic [1:0]        tgt_oh;
   logic [1:0]        active_v;
   logic [1:0]        hready_v;
   logic              tgt_go;
   logic              valid_live;
   logic              req;
   logic              acc_live;
   logic              acc_held;
   logic              load;
   logic              miss_live;
   logic              dphase_done;
   logic              owner_ready;
   logic              owner_resp;

   // Address phase presented downstream: the held copy while pending, else live
   assign HADDRI     = pend_reg ? held_addr_reg  : HADDRS;
   assign HTRANSI    = pend_reg ? held_trans_reg : HTRANSS;
   assign HWRITEI    = pend_reg ? held_write_reg : HWRITES;
   assign HSIZEI     = pend_reg ? held_size_reg  : HSIZES;
   assign HBURSTI    = pend_reg ? held_burst_reg : HBURSTS;
   assign HPROTI     = pend_reg ? held_prot_reg  : HPROTS;
   assign HMASTLOCKI = pend_reg ? held_lock_reg  : HMASTLOCKS;

   assign active_v = {active_m1, active_m0};
   assign hready_v = {hready_m1, hready_m0};

   // Region decode on the muxed address
   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_dec
      localparam logic [ADDR_W-1:0] BASE = (gi == 0) ? M0_BASE : M1_BASE;
      localparam logic [ADDR_W-1:0] MASK = (gi == 0) ? M0_MASK : M1_MASK;
      assign hit[gi] = (HADDRI & MASK) == BASE;
   end

   // Output 0 wins when both regions match
   assign tgt_oh[0] = hit[0];
   assign tgt_oh[1] = ~hit[0] & hit[1];
   assign tgt_go    = |(tgt_oh & active_v & hready_v);

   // A live transfer cannot coexist with a pending one; gating on pend keeps a
   // stray HREADYS from overwriting the held phase.
   assign valid_live = HSELS & HREADYS & HTRANSS[1] & ~pend_reg;
   assign req        = (pend_reg | valid_live) & HTRANSI[1];
   assign sel_m0     = req & tgt_oh[0];
   assign sel_m1     = req & tgt_oh[1];

   assign acc_live  = valid_live & tgt_go;
   assign load      = valid_live & (|tgt_oh) & ~tgt_go;
   assign miss_live = valid_live & ~(|tgt_oh);
   assign acc_held  = pend_reg & tgt_go;

   always_comb begin
      owner_ready = 1'b1;
      owner_resp  = 1'b0;
      case (dsel_reg)
         DS_M0: begin
            owner_ready = readyout_m0;
            owner_resp  = resp_m0;
         end
         DS_M1: begin
            owner_ready = readyout_m1;
            owner_resp  = resp_m1;
         end
         default: begin
            owner_ready = 1'b1;
            owner_resp  = 1'b0;
         end
      endcase
   end

   // A miss data phase (OKAY build) finishes in its single cycle
   assign dphase_done = (dsel_reg != DS_NONE) & owner_ready;

   // Next pend / data-phase owner. An accepted address always wins over the
   // completion of the previous data phase, so a simultaneous pend clear and
   // completion hands ownership straight to the new target.
   always_comb begin
      pend_next = pend_reg;
      dsel_next = dsel_reg;
      if (acc_live || acc_held) begin
         dsel_next = tgt_oh[0] ? DS_M0 : DS_M1;
      end else if (miss_live) begin
`ifdef L1_AHB_MTX_IN_STG_DEFSLV_EN
         dsel_next = DS_NONE;
`else
         dsel_next = DS_MISS;
`endif
      end else if (dphase_done) begin
         dsel_next = DS_NONE;
      end
      if (load) begin
         pend_next = 1'b1;
      end else if (acc_held) begin
         pend_next = 1'b0;
      end
      if (pend_next && dsel_next != DS_NONE) begin
         state_next = ST_DATA_PEND;
      end else if (pend_next) begin
         state_next = ST_PEND;
      end else if (dsel_next != DS_NONE) begin
         state_next = ST_DATA;
      end else begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg <= ST_IDLE;
         pend_reg  <= 1'b0;
         dsel_reg  <= DS_NONE;
      end else begin
         pend_reg <= pend_next;
         dsel_reg <= dsel_next;
`ifdef L1_AHB_MTX_IN_STG_DEFSLV_EN
         if (miss_live) begin
            state_reg <= ST_ERR1;
         end else if (state_reg == ST_ERR1) begin
            state_reg <= ST_ERR2;
         end else begin
            state_reg <= state_next;
         end
`else
         state_reg <= state_next;
`endif
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         held_addr_reg  <= '0;
         held_trans_reg <= '0;
         held_write_reg <= 1'b0;
         held_size_reg  <= '0;
         held_burst_reg <= '0;
         held_prot_reg  <= '0;
         held_lock_reg  <= 1'b0;
      end else if (load) begin
         held_addr_reg  <= HADDRS;
         held_trans_reg <= HTRANSS;
         held_write_reg <= HWRITES;
         held_size_reg  <= HSIZES;
         held_burst_reg <= HBURSTS;
         held_prot_reg  <= HPROTS;
         held_lock_reg  <= HMASTLOCKS;
      end
   end

   // Master-facing ready/response
   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            HREADYOUTS = 1'b1;
            HRESPS     = 1'b0;
         end
         ST_PEND, ST_DATA_PEND: begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b0;
         end
         ST_DATA: begin
            HREADYOUTS = owner_ready;
            HRESPS     = owner_resp;
         end
`ifdef L1_AHB_MTX_IN_STG_DEFSLV_EN
         ST_ERR1: begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b1;
         end
         ST_ERR2: begin
            HREADYOUTS = 1'b1;
            HRESPS     = 1'b1;
         end
`endif
         default: begin
            HREADYOUTS = 1'b1;
            HRESPS     = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_l1_ahb_mtx_in_stg.sv
// -----------------------------------------------------------------------------
// tb_l1_ahb_mtx_in_stg
// Self-checking bench for l1_ahb_mtx_in_stg. A transaction-level model (held
// transfer, data-phase owner, error phase) predicts the master-facing outputs
// and requests every cycle; a queue checks that addresses reach the outputs in
// issue order, exactly once. Directed sequences pin the model with literal
// expectations, then randomized traffic runs against it.
// -----------------------------------------------------------------------------
module tb_l1_ahb_mtx_in_stg;

   localparam logic [31:0] M0_BASE = 32'h0000_0000;
   localparam logic [31:0] M0_MASK = 32'hE000_0000;
   localparam logic [31:0] M1_BASE = 32'h2000_0000;
   localparam logic [31:0] M1_MASK = 32'hE000_0000;
`ifdef L1_AHB_MTX_IN_STG_DEFSLV_EN
   localparam bit DEFSLV = 1'b1;
`else
   localparam bit DEFSLV = 1'b0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSELS;
   logic [31:0] HADDRS;
   logic [1:0]  HTRANSS;
   logic        HWRITES;
   logic [2:0]  HSIZES;
   logic [2:0]  HBURSTS;
   logic [3:0]  HPROTS;
   logic        HMASTLOCKS;
   logic        HREADYS;
   logic        HREADYOUTS;
   logic        HRESPS;
   logic [31:0] HADDRI;
   logic [1:0]  HTRANSI;
   logic        HWRITEI;
   logic [2:0]  HSIZEI;
   logic [2:0]  HBURSTI;
   logic [3:0]  HPROTI;
   logic        HMASTLOCKI;
   logic        sel_m0, sel_m1;
   logic        active_m0, active_m1;
   logic        hready_m0, hready_m1;
   logic        readyout_m0, readyout_m1;
   logic        resp_m0, resp_m1;

   assign HREADYS = HREADYOUTS;

   always #5 HCLK = ~HCLK;

   l1_ahb_mtx_in_stg #(
      .ADDR_W (32),
      .M0_BASE(M0_BASE),
      .M0_MASK(M0_MASK),
      .M1_BASE(M1_BASE),
      .M1_MASK(M1_MASK)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HSELS      (HSELS),
      .HADDRS     (HADDRS),
      .HTRANSS    (HTRANSS),
      .HWRITES    (HWRITES),
      .HSIZES     (HSIZES),
      .HBURSTS    (HBURSTS),
      .HPROTS     (HPROTS),
      .HMASTLOCKS (HMASTLOCKS),
      .HREADYS    (HREADYS),
      .HREADYOUTS (HREADYOUTS),
      .HRESPS     (HRESPS),
      .HADDRI     (HADDRI),
      .HTRANSI    (HTRANSI),
      .HWRITEI    (HWRITEI),
      .HSIZEI     (HSIZEI),
      .HBURSTI    (HBURSTI),
      .HPROTI     (HPROTI),
      .HMASTLOCKI (HMASTLOCKI),
      .sel_m0     (sel_m0),
      .sel_m1     (sel_m1),
      .active_m0  (active_m0),
      .active_m1  (active_m1),
      .hready_m0  (hready_m0),
      .hready_m1  (hready_m1),
      .readyout_m0(readyout_m0),
      .readyout_m1(readyout_m1),
      .resp_m0    (resp_m0),
      .resp_m1    (resp_m1)
   );

   int errors = 0;
   int checks = 0;

   // Model: one held transfer, data-phase owner (-1 none, 0, 1, 2 miss),
   // error phase counter (0 none, 1 first cycle, 2 second cycle)
   bit          m_held;
   logic [45:0] m_hbus;
   int          m_owner;
   int          m_err;
   logic [32:0] exp_q[$];
   logic [31:0] acc_log[$];
   bit          log_en;
   bit          last_rdy;
   bit          rst_prev;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [31:0] a);
      if ((a & M0_MASK) == M0_BASE) return 0;
      if ((a & M1_MASK) == M1_BASE) return 1;
      return 2;
   endfunction

   // Called at the falling edge: compare this cycle, then advance the model.
   task automatic model_step();
      logic [45:0] live_bus, cur_bus, dut_bus;
      logic [31:0] cur_addr;
      logic [32:0] e;
      int t;
      bit exp_rdy, exp_resp, valid, req, act_t, rdy_t, done, acc_live, load, miss, acc_held;
      live_bus = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
      dut_bus  = {HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI};
      cur_bus  = m_held ? m_hbus : live_bus;
      cur_addr = cur_bus[45:14];
      t = decode(cur_addr);

      if (m_held || m_err == 1) exp_rdy = 1'b0;
      else if (m_err == 2)      exp_rdy = 1'b1;
      else if (m_owner == 0)    exp_rdy = readyout_m0;
      else if (m_owner == 1)    exp_rdy = readyout_m1;
      else                      exp_rdy = 1'b1;

      if (m_err != 0)        exp_resp = 1'b1;
      else if (m_held)       exp_resp = 1'b0;
      else if (m_owner == 0) exp_resp = resp_m0;
      else if (m_owner == 1) exp_resp = resp_m1;
      else                   exp_resp = 1'b0;

      valid = !m_held && HSELS && exp_rdy && HTRANSS[1];
      req   = m_held || valid;

      check("hreadyout", HREADYOUTS, exp_rdy);
      check("hresp", HRESPS, exp_resp);
      check("sel_m0", sel_m0, req && t == 0);
      check("sel_m1", sel_m1, req && t == 1);
      check("addr_bus", dut_bus, cur_bus);

      if (!HRESET) begin
         if (valid && t < 2) exp_q.push_back({t[0], cur_addr});
         if (sel_m0 && active_m0 && hready_m0) begin
            if (log_en) acc_log.push_back(HADDRI);
            if (exp_q.size() == 0) check("accept_m0_outstanding", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("accept_order_m0", {1'b0, HADDRI}, e);
            end
         end
         if (sel_m1 && active_m1 && hready_m1) begin
            if (exp_q.size() == 0) check("accept_m1_outstanding", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("accept_order_m1", {1'b1, HADDRI}, e);
            end
         end
      end

      act_t = (t == 0) ? active_m0 : (t == 1) ? active_m1 : 1'b0;
      rdy_t = (t == 0) ? hready_m0 : (t == 1) ? hready_m1 : 1'b0;
      acc_live = valid && t < 2 && act_t && rdy_t;
      load     = valid && t < 2 && !(act_t && rdy_t);
      miss     = valid && t == 2;
      acc_held = m_held && act_t && rdy_t;
      done     = (m_owner == 0) ? readyout_m0 : (m_owner == 1) ? readyout_m1 : (m_owner == 2);

      if (HRESET) begin
         m_held  = 1'b0;
         m_hbus  = '0;
         m_owner = -1;
         m_err   = 0;
         exp_q.delete();
      end else begin
         if (acc_live)      m_owner = t;
         else if (miss)     m_owner = DEFSLV ? -1 : 2;
         else if (acc_held) m_owner = t;
         else if (done)     m_owner = -1;
         if (load) begin
            m_held = 1'b1;
            m_hbus = live_bus;
         end else if (acc_held) begin
            m_held = 1'b0;
         end
         if (DEFSLV && miss) m_err = 1;
         else if (m_err == 1) m_err = 2;
         else m_err = 0;
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
      model_step();
      last_rdy = HREADYOUTS;
      rst_prev = HRESET;
   endtask

   task automatic adv();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_idle();
      HSELS = 1'b1; HTRANSS = 2'b00; HADDRS = '0; HWRITES = 1'b0;
      HSIZES = 3'b010; HBURSTS = 3'b000; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
   endtask

   task automatic set_xfer(input logic [31:0] a, input logic [1:0] tr, input logic [2:0] bu);
      HSELS = 1'b1; HTRANSS = tr; HADDRS = a; HWRITES = 1'b1;
      HSIZES = 3'b010; HBURSTS = bu; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] x;
      int r;
      x = $urandom();
      r = $urandom_range(0, 4);
      if (r < 2)       x[31:29] = 3'b000;
      else if (r < 4)  x[31:29] = 3'b001;
      else             x[31:29] = 3'($urandom_range(2, 7));
      x[1:0] = 2'b00;
      return x;
   endfunction

   task automatic rand_master();
      int r;
      if (rst_prev) begin
         set_idle();
      end else if (last_rdy) begin
         r = $urandom_range(0, 9);
         HSELS = ($urandom_range(0, 7) != 0);
         HWRITES = 1'($urandom_range(0, 1));
         HPROTS = 4'($urandom_range(0, 15));
         HMASTLOCKS = ($urandom_range(0, 7) == 0);
         if (r < 3) begin
            HTRANSS = 2'b00;
         end else if (r == 3) begin
            HTRANSS = 2'b01;
         end else if (r < 7 || HTRANSS == 2'b00) begin
            HTRANSS = 2'b10;
            HADDRS = rand_addr();
            HBURSTS = 3'($urandom_range(0, 7));
         end else begin
            HTRANSS = 2'b11;
            HADDRS = HADDRS + 32'd4;
         end
      end
   endtask

   task automatic rand_outputs();
      active_m0   = ($urandom_range(0, 3) != 0);
      active_m1   = ($urandom_range(0, 3) != 0);
      hready_m0   = ($urandom_range(0, 3) != 0);
      hready_m1   = ($urandom_range(0, 3) != 0);
      readyout_m0 = ($urandom_range(0, 3) != 0);
      readyout_m1 = ($urandom_range(0, 3) != 0);
      resp_m0     = ($urandom_range(0, 7) == 0);
      resp_m1     = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      int beat;
      bit burst_ok;
      HRESET = 1'b1;
      set_idle();
      active_m0 = 1'b0; active_m1 = 1'b0; hready_m0 = 1'b1; hready_m1 = 1'b1;
      readyout_m0 = 1'b1; readyout_m1 = 1'b1; resp_m0 = 1'b0; resp_m1 = 1'b0;
      m_held = 1'b0; m_hbus = '0; m_owner = -1; m_err = 0;
      log_en = 1'b0; last_rdy = 1'b1; rst_prev = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      // Reset state
      tick();
      check("reset_hreadyout", HREADYOUTS, 1);
      check("reset_hresp", HRESPS, 0);
      check("reset_sel", {sel_m1, sel_m0}, 2'b00);
      check("reset_haddri", HADDRI, 32'h0);
      adv();

      // Zero-latency path to output 0
      active_m0 = 1'b1; hready_m0 = 1'b1; readyout_m0 = 1'b1;
      set_xfer(32'h0000_0010, 2'b10, 3'b000);
      tick();
      check("zl_sel_m0", {sel_m1, sel_m0}, 2'b01);
      check("zl_addr_ready", HREADYOUTS, 1);
      $display("txn zero-latency addr=%h sel_m0=%0d", HADDRI, sel_m0);
      adv();
      set_idle(); readyout_m0 = 1'b0;
      tick();
      check("zl_data_wait", HREADYOUTS, 0);
      adv();
      readyout_m0 = 1'b1;
      tick();
      check("zl_data_done", HREADYOUTS, 1);
      adv();

      // Held path to output 1
      active_m1 = 1'b0; hready_m1 = 1'b1; readyout_m1 = 1'b1;
      set_xfer(32'h2000_0040, 2'b10, 3'b000);
      tick();
      check("hold_first_sel_m1", sel_m1, 1);
      adv();
      set_idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_stall", HREADYOUTS, 0);
         check("hold_haddri", HADDRI, 32'h2000_0040);
         check("hold_sel_m1", sel_m1, 1);
         adv();
      end
      active_m1 = 1'b1;
      tick();
      check("hold_grant_stall", HREADYOUTS, 0);
      adv();
      tick();
      check("hold_data_ready", HREADYOUTS, 1);
      check("hold_done_sel", {sel_m1, sel_m0}, 2'b00);
      $display("txn held addr=20000040 delivered after grant");
      adv();

      // Decode miss
      set_xfer(32'h8000_0000, 2'b10, 3'b000);
      tick();
      check("miss_sel", {sel_m1, sel_m0}, 2'b00);
      adv();
      set_idle();
      tick();
      check("miss_c1", {HREADYOUTS, HRESPS}, DEFSLV ? 2'b01 : 2'b10);
      check("miss_c1_sel", {sel_m1, sel_m0}, 2'b00);
      adv();
      tick();
      check("miss_c2", {HREADYOUTS, HRESPS}, DEFSLV ? 2'b11 : 2'b10);
      $display("txn miss addr=80000000 defslv=%0d", DEFSLV);
      adv();
      tick();
      adv();

      // Reset while a transfer is held
      active_m1 = 1'b0;
      set_xfer(32'h2000_0080, 2'b10, 3'b000);
      tick();
      adv();
      set_idle();
      HRESET = 1'b1;
      tick();
      check("rst_pend_stall", HREADYOUTS, 0);
      adv();
      HRESET = 1'b0;
      tick();
      check("rst_after_ready", HREADYOUTS, 1);
      check("rst_after_sel", {sel_m1, sel_m0}, 2'b00);
      adv();
      set_xfer(32'h0000_0020, 2'b10, 3'b000);
      tick();
      check("rst_new_sel_m0", sel_m0, 1);
      adv();
      set_idle();
      tick();
      check("rst_new_data", HREADYOUTS, 1);
      $display("txn reset-during-pend recovered");
      adv();
      tick();
      adv();

      // INCR4 to output 0 with hready_m0 dropping mid-burst
      active_m0 = 1'b1; readyout_m0 = 1'b1; resp_m0 = 1'b0;
      log_en = 1'b1;
      acc_log.delete();
      beat = 0;
      burst_ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         hready_m0 = (k % 3 != 1);
         if (beat < 4) set_xfer(32'(beat * 4), (beat == 0) ? 2'b10 : 2'b11, 3'b011);
         else set_idle();
         tick();
         if (HREADYOUTS && beat < 4) beat++;
         adv();
         if (beat >= 4 && acc_log.size() >= 4) begin
            burst_ok = 1'b1;
            break;
         end
      end
      check("burst_complete", burst_ok, 1);
      check("burst_beats", acc_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < acc_log.size()) begin
            check("burst_addr", acc_log[i], 32'(i * 4));
            $display("txn burst beat %0d addr=%h", i, acc_log[i]);
         end
      end
      log_en = 1'b0;
      hready_m0 = 1'b1;
      set_idle();
      tick();
      adv();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         HRESET = ($urandom_range(0, 399) == 0);
         rand_master();
         rand_outputs();
         tick();
         if (sel_m0 || sel_m1)
            $display("txn c=%0d addr=%h sel=%0d%0d rdy=%0d", c, HADDRI, sel_m1, sel_m0, HREADYOUTS);
         adv();
      end

      // Drain: grant everything, master goes idle once its phase completes
      HRESET = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (last_rdy || rst_prev) set_idle();
         active_m0 = 1'b1; active_m1 = 1'b1; hready_m0 = 1'b1; hready_m1 = 1'b1;
         readyout_m0 = 1'b1; readyout_m1 = 1'b1; resp_m0 = 1'b0; resp_m1 = 1'b0;
         tick();
         adv();
      end
      check("drain_outstanding", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
